user_io_tx_arbiter: RTL
=======================

// Module: user_io_tx_arbiter
// PURPOSE
//  Shares one user IO request port (uio_rq_*) between NUM_REQ personality requesters.
//  Each requester gets a FIFO. A packet-atomic round-robin scheduler drains the FIFOs
//  onto the port, obeying the port's almost-full backpressure and the link status.
//  Sits in the clk_per domain between personality logic and one user_io_axi_conv lane.
// PARAMETERS
//  NUM_REQ          4    number of requesters (2..8)
//  UIO_PORTS_WIDTH  128  data width per beat
//  FIFO_DEPTH       16   entries per requester FIFO (power of 2)
//  AFULL_MARGIN     4    req_afull[i] asserts when FIFO count >= FIFO_DEPTH-AFULL_MARGIN
// PORTS
//  clk_per       in   1                      clock
//  reset_per     in   1                      asynchronous reset, active-high
//  req_vld       in   NUM_REQ                per-requester beat valid (push, no ready)
//  req_data      in   NUM_REQ*UIO_PORTS_WIDTH  beat data, requester i at slice i
//  req_last      in   NUM_REQ                last beat of packet
//  req_afull     out  NUM_REQ                FIFO almost full, requester must stop within margin
//  req_ovfl      out  NUM_REQ                sticky: push into full FIFO was dropped
//  i_stat_chan_up in  1                      link up (already synchronised to clk_per)
//  uio_rq_vld    out  1                      beat valid to port
//  uio_rq_data   out  UIO_PORTS_WIDTH        beat data
//  uio_rq_src    out  log2(NUM_REQ) (min 1)  source requester of current beat
//  uio_rq_afull  in   1                      port almost full
//  o_busy        out  1                      FSM not IDLE or any FIFO non-empty
// BEHAVIOUR
//  Reset: all outputs 0, FIFOs empty, FSM IDLE, RR pointer = NUM_REQ-1 (first search starts at 0).
//  FIFO i: push when req_vld[i]. If full, drop the beat and set req_ovfl[i] (cleared only by reset).
//   Each entry stores {last,data}. Push and pop in the same cycle are legal; count stays unchanged.
//   req_afull is registered from count and reflects pushes/pops one cycle later.
//  can_issue = i_stat_chan_up & ~uio_rq_afull.
//  FSM:
//   IDLE: if can_issue and any FIFO non-empty, grant g = first non-empty index after RR pointer
//         (wrapping). Pop head of g and go to SEND. If the popped beat has last=1, the packet is
//         complete: RR pointer = g and stay IDLE.
//   SEND: locked to g. Pop when can_issue and FIFO g non-empty.
//         On popping a beat with last=1: RR pointer = g, go to IDLE.
//         If FIFO g is empty, wait in SEND. No other requester is served, so packets never interleave.
//  Output: popped beat appears on uio_rq_vld/data/src exactly 1 cycle after pop (registered).
//   uio_rq_vld=0 in any cycle with no pop.
//  Max throughput is 1 beat/cycle, including back-to-back packets from different requesters.
//   An IDLE grant pops in the same cycle it is decided.
//  Backpressure: uio_rq_afull or ~i_stat_chan_up stalls pops on the next cycle.
//   No beat is lost; the FSM state and lock are held.
//  Link drop mid-packet: stall only. Resume the same packet when the link returns.
//  RR rotates only at packet completion. A requester with a long packet cannot be preempted.
//  Simultaneous last-pop and a new non-empty FIFO: the next grant is evaluated in the following
//   cycle from the updated pointer.
//  Reset asserted mid-packet: immediate return to reset state. FIFO contents are discarded and
//   the partial packet is lost.
// TESTING
//  1 Reset: assert reset_per mid-stream -> all outputs 0 asynchronously; after release o_busy=0.
//  2 Single: req0 pushes 3 beats (last on 3rd), link up, afull=0 -> uio_rq_vld high 3
//    consecutive cycles, src=0, data in order.
//  3 RR fairness: req0,1,2 each push 2 two-beat packets at once -> output src order
//    0,0,1,1,2,2,0,0,1,1,2,2 with no idle cycles.
//  4 Atomicity: req1 packet of 4 beats pushed 1 beat every 3 cycles while req2 is full ->
//    all 4 req1 beats precede any req2 beat.
//  5 Backpressure: uio_rq_afull=1 for 10 cycles mid-packet -> no uio_rq_vld during the stall
//    (after 1-cycle latency); all beats delivered after release.
//    Repeat with i_stat_chan_up=0.
//  6 Overflow: 20 back-to-back beats into req3 with afull=1 downstream (FIFO_DEPTH=16) ->
//    req_afull[3] high after 12 beats, req_ovfl[3]=1, exactly 16 beats delivered after release.

Source files
------------

// File: rtl/user_io_tx_arbiter.sv
// ---------------------------------------------------------------------------
// user_io_tx_arbiter
//
// Shares one user IO request port between NUM_REQ personality requesters.
// Every requester pushes beats into its own FIFO. A packet-atomic round-robin
// scheduler drains those FIFOs onto the port. It honours the port's
// almost-full backpressure and the link status. Lives in the clk_per domain.
//
// Ports
//   clk_per         clock
//   reset_per       asynchronous reset, active-high
//   req_vld         per-requester beat valid (push only, there is no ready)
//   req_data        beat data, requester i occupies slice i
//   req_last        last beat of a packet
//   req_afull       FIFO almost full (registered), requester must stop soon
//   req_ovfl        sticky: a push into a full FIFO was dropped
//   i_stat_chan_up  link up, already synchronised to clk_per
//   uio_rq_vld      beat valid to the port
//   uio_rq_data     beat data to the port
//   uio_rq_src      requester that produced the current beat
//   uio_rq_afull    port almost full
//   o_busy          scheduler mid-packet or any FIFO still holding data
// ---------------------------------------------------------------------------
module user_io_tx_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int UIO_PORTS_WIDTH = 128,
  parameter int FIFO_DEPTH      = 16,
  parameter int AFULL_MARGIN    = 4,
  localparam int SRC_W          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk_per,
  input  logic                               reset_per,
  input  logic [NUM_REQ-1:0]                 req_vld,
  input  logic [NUM_REQ*UIO_PORTS_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]                 req_last,
  output logic [NUM_REQ-1:0]                 req_afull,
  output logic [NUM_REQ-1:0]                 req_ovfl,
  input  logic                               i_stat_chan_up,
  output logic                               uio_rq_vld,
  output logic [UIO_PORTS_WIDTH-1:0]         uio_rq_data,
  output logic [SRC_W-1:0]                   uio_rq_src,
  input  logic                               uio_rq_afull,
  output logic                               o_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = UIO_PORTS_WIDTH + 1;
  localparam logic [CNT_W-1:0] AFULL_LEVEL = CNT_W'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [CNT_W-1:0] FULL_LEVEL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SEND
  } state_t;

  state_t             state;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   rr_ptr;

  logic [NUM_REQ-1:0] fifo_empty;
  logic [ENT_W-1:0]   fifo_head [NUM_REQ];

  logic               can_issue;
  logic               rr_found;
  logic [SRC_W-1:0]   rr_sel;
  logic               pop_en;
  logic [SRC_W-1:0]   pop_idx;
  logic [ENT_W-1:0]   pop_head;
  logic               pop_last;

  assign can_issue = i_stat_chan_up & ~uio_rq_afull;

  // Per-requester FIFOs. Each entry is {last, data}. A push into a full FIFO
  // is dropped and flagged. The full check uses the current count, so a
  // same-cycle pop does not make room for that push.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             afull_q;
    logic             ovfl_q;

    assign full    = (count == FULL_LEVEL);
    assign do_push = req_vld[i] & ~full;
    assign do_pop  = pop_en & (pop_idx == SRC_W'(i));

    // Storage array. It has no reset because the pointers and count define
    // what is valid.
    always_ff @(posedge clk_per) begin
      if (do_push) begin
        mem[wr_ptr] <= {req_last[i], req_data[i*UIO_PORTS_WIDTH +: UIO_PORTS_WIDTH]};
      end
    end

    // Pointer and occupancy tracking. The almost-full flag is registered from
    // the count, so it lags occupancy changes by one cycle. The margin must
    // absorb that lag.
    always_ff @(posedge clk_per or posedge reset_per) begin
      if (reset_per) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        afull_q <= 1'b0;
        ovfl_q  <= 1'b0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
        if (req_vld[i] && full) begin
          ovfl_q <= 1'b1;
        end
        afull_q <= (count >= AFULL_LEVEL);
      end
    end

    assign fifo_empty[i] = (count == '0);
    assign fifo_head[i]  = mem[rd_ptr];
    assign req_afull[i]  = afull_q;
    assign req_ovfl[i]   = ovfl_q;
  end

  // Round-robin search. It finds the first non-empty FIFO strictly after the
  // pointer and wraps around. The pointer only moves at packet completion.
  // As a result, the requester that just finished has the lowest priority
  // for the next grant.
  always_comb begin
    logic [SRC_W-1:0] cand;
    rr_found = 1'b0;
    rr_sel   = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!rr_found && !fifo_empty[cand]) begin
        rr_found = 1'b1;
        rr_sel   = cand;
      end
    end
  end

  // Pop decision. An IDLE grant pops in the cycle it is decided, so
  // back-to-back packets from different requesters leave no bubble. In SEND
  // only the locked requester may pop, which keeps packets unbroken across
  // stalls and link drops.
  always_comb begin
    pop_en  = 1'b0;
    pop_idx = grant;
    case (state)
      ST_IDLE: begin
        if (can_issue && rr_found) begin
          pop_en  = 1'b1;
          pop_idx = rr_sel;
        end
      end
      ST_SEND: begin
        if (can_issue && !fifo_empty[grant]) begin
          pop_en = 1'b1;
        end
      end
      default: begin
        pop_en = 1'b0;
      end
    endcase
  end

  assign pop_head = fifo_head[pop_idx];
  assign pop_last = pop_head[ENT_W-1];

  // Scheduler FSM plus registered port outputs. A popped beat shows up on the
  // port the cycle after the pop. Data and src hold their value while vld is
  // low. A single-beat packet finishes in IDLE and never enters SEND.
  always_ff @(posedge clk_per or posedge reset_per) begin
    if (reset_per) begin
      state       <= ST_IDLE;
      grant       <= '0;
      rr_ptr      <= SRC_W'(NUM_REQ - 1);
      uio_rq_vld  <= 1'b0;
      uio_rq_data <= '0;
      uio_rq_src  <= '0;
    end else begin
      uio_rq_vld <= pop_en;
      if (pop_en) begin
        uio_rq_data <= pop_head[UIO_PORTS_WIDTH-1:0];
        uio_rq_src  <= pop_idx;
      end
      case (state)
        ST_IDLE: begin
          if (pop_en) begin
            grant <= pop_idx;
            if (pop_last) begin
              rr_ptr <= pop_idx;
            end else begin
              state <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (pop_en && pop_last) begin
            rr_ptr <= grant;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state != ST_IDLE) | ~(&fifo_empty);

endmodule
